sorted_drain: RTL and testbench
===============================

# sorted_drain

Read-out end of the linear sorter chain. On `start` it snapshots the parallel contents of the sorter cells (data plus empty flags) and streams the occupied entries out in ascending order over a valid/ready interface, tagging the final entry with `out_last`. After the last transfer it pulses `sorter_clear` so the sorter chain can be flushed and refilled. It sits between the sorter chain and any downstream stream consumer.

## Interface
- `N_CELLS`, default 8: number of sorter cells observed; must be ≥ 1.
- `WIDTH`, default 8: data width per cell.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a drain; sampled only in IDLE.
- `cell_data_bus`  in  N_CELLS*WIDTH  sorter cell data; cell 0 (smallest) in bits [WIDTH-1:0], cell i in [i*WIDTH +: WIDTH].
- `cell_empty`  in  N_CELLS  per-cell empty flag; bit i belongs to cell i.
- `out_data`  out  WIDTH  current entry; 0 whenever `out_valid`=0.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  consumer accepts the entry when high together with `out_valid`.
- `out_last`  out  1  the current valid entry is the final one of this drain.
- `out_count`  out  $clog2(N_CELLS+1)  number of entries captured in the current or most recent drain.
- `busy`  out  1  high in every state except IDLE.
- `sorter_clear`  out  1  one-cycle, active-high flush pulse to the sorter chain.
- `done`  out  1  one-cycle pulse marking the end of a drain; coincides with `sorter_clear`.

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE, `start`=1: on the edge, copy all `cell_data_bus` slices into an internal snapshot and set `out_count` = number of leading contiguous cells with `cell_empty`=0, counted from cell 0. The scan stops at the first empty cell, so any occupied cells after a gap are ignored. Next state: STREAM if the count is > 0, otherwise FLUSH.
- STREAM: `out_valid`=1. `out_data` = snapshot[idx], with idx starting at 0. `out_last` = (idx == `out_count`-1).
  - On a handshake (`out_valid` & `out_ready`) with `out_last`=0, idx increments.
  - On a handshake with `out_last`=1, next state is FLUSH.
  - While `out_ready`=0, `out_data`, `out_last` and idx hold; `out_valid` never drops before its handshake.
- FLUSH (exactly one cycle): `sorter_clear`=1 and `done`=1, then return to IDLE. idx returns to 0. `out_count` keeps its value until the next capture.
- `start` is ignored in STREAM and FLUSH; no request is queued.
- Live changes on `cell_data_bus` / `cell_empty` after the capture edge have no effect. The system must not push new data into the sorter while `busy`=1.
- Reset (`reset`=0, any time including mid-stream): immediately go to IDLE. Clear idx, `out_count` and the snapshot to 0. All outputs go to 0: `out_data`, `out_valid`, `out_last`, `out_count`, `busy`, `sorter_clear`, `done`. No flush pulse is generated by reset.

## Timing
- `start` high at edge t → `busy` and `out_valid` high from t+1 (single-cycle capture latency).
- With `out_ready` held high, one entry transfers per cycle. k entries occupy edges t+1 … t+k; FLUSH is the cycle after edge t+k; IDLE resumes after edge t+k+1.
- Empty snapshot: FLUSH is the cycle after edge t; IDLE after edge t+1.
- Minimum spacing between back-to-back drains: `start` may be re-asserted in the first IDLE cycle after FLUSH.
- All outputs are registered or decoded from state/idx only; none depends combinationally on `out_ready`.

## Test plan
- Snapshot {3,7,9,20,_,_,_,_} (cells 0–3 full), `start` pulse, `out_ready`=1 → `out_data` 3,7,9,20 on consecutive cycles, `out_last` only with 20, `out_count`=4, then one cycle of `sorter_clear`=`done`=1.
- All cells empty, `start` → `out_valid` never asserts, `out_count`=0, `sorter_clear`/`done` pulse in the cycle after capture.
- Full 8-cell snapshot 1..8 with `out_ready` toggling 1,0,0,1… → each value held stable while stalled, exactly 8 transfers in order, `out_last` on 8.
- After capture, change `cell_data_bus` to all 0xFF → streamed values still match the captured snapshot.
- `cell_empty`=0b11110100 (cells 0,1,3 full; cell 2 empty) → only cells 0 and 1 streamed, `out_count`=2.
- Assert `reset`=0 mid-stream after 2 transfers → outputs zero immediately, no `sorter_clear`. After release, a new `start` drains correctly from idx 0.

Source files
------------

// File: rtl/sorted_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : sorted_drain_if
// Description : Valid/ready output stream of the sorter drain, carrying the
//               entry data and an end-of-drain marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface sorted_drain_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    // Drain side: produces entries, observes back-pressure.
    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    // Consumer side: accepts entries.
    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sorted_drain.sv
`default_nettype none
// ============================================================================
// Module      : sorted_drain
// Description : Snapshots the sorter cell chain on start and streams the
//               leading occupied cells out in ascending order, marking the
//               final entry, then pulses a one-cycle sorter flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sorted_drain #(
    parameter  int N_CELLS = 8,
    parameter  int WIDTH   = 8,
    localparam int CW      = $clog2(N_CELLS + 1)
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       start,
    input  wire logic [N_CELLS*WIDTH-1:0]   cell_data_bus,
    input  wire logic [N_CELLS-1:0]         cell_empty,
    sorted_drain_if.master                  out,
    output logic      [CW-1:0]              out_count,
    output logic                            busy,
    output logic                            sorter_clear,
    output logic                            done
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_snap [N_CELLS];
    logic [WIDTH-1:0] w_cell [N_CELLS];
    logic [CW-1:0]    w_lead;
    logic [WIDTH-1:0] w_sel;
    logic             w_last;

    // Unpack the flat cell bus into one word per cell.
    genvar gi;
    generate
        for (gi = 0; gi < N_CELLS; gi++) begin : g_cells
            assign w_cell[gi] = cell_data_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Count occupied cells from cell 0 up to the first empty one; anything
    // occupied beyond a gap is deliberately not drained.
    always_comb begin
        logic w_stop;
        w_lead = '0;
        w_stop = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (!w_stop) begin
                if (!cell_empty[i]) begin
                    w_lead = w_lead + CW'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    // Select the snapshot entry addressed by the stream index.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (r_idx == CW'(i)) begin
                w_sel = r_snap[i];
            end
        end
    end

    assign w_last    = (r_idx == (r_count - CW'(1)));
    assign out_count = r_count;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an empty snapshot goes straight to the flush cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_lead != '0) ? c_STREAM : c_FLUSH;
                end
            end
            c_STREAM: begin
                if (out.out_ready && w_last) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Snapshot capture, entry count and stream index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_count <= '0;
            for (int i = 0; i < N_CELLS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_count <= w_lead;
                        r_idx   <= '0;
                        for (int i = 0; i < N_CELLS; i++) begin
                            r_snap[i] <= w_cell[i];
                        end
                    end
                end
                c_STREAM: begin
                    if (out.out_ready && !w_last) begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                c_FLUSH: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from state and index only, never from out_ready.
    always_comb begin
        out.out_data  = '0;
        out.out_valid = 1'b0;
        out.out_last  = 1'b0;
        sorter_clear  = 1'b0;
        done          = 1'b0;
        busy          = (r_state != c_IDLE);
        case (r_state)
            c_STREAM: begin
                out.out_valid = 1'b1;
                out.out_data  = w_sel;
                out.out_last  = w_last;
            end
            c_FLUSH: begin
                sorter_clear = 1'b1;
                done         = 1'b1;
            end
            default: begin
                busy = (r_state != c_IDLE);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sorted_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_sorted_drain
// Description : Directed self-checking bench for sorted_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sorted_drain;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] cell_data_bus;
    logic [7:0]  cell_empty;
    logic [3:0]  out_count;
    logic        busy;
    logic        sorter_clear;
    logic        done;

    int errors = 0;
    int checks = 0;

    sorted_drain_if #(.WIDTH(8)) bus_if ();

    sorted_drain #(.N_CELLS(8), .WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cell_data_bus (cell_data_bus),
        .cell_empty    (cell_empty),
        .out           (bus_if.master),
        .out_count     (out_count),
        .busy          (busy),
        .sorter_clear  (sorter_clear),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stream n entries with out_ready held high, then check the flush cycle.
    task automatic run_stream(input string name, input int n, input logic [63:0] vals);
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_valid%0d", name, k), bus_if.out_valid, 1);
            chk($sformatf("%s_data%0d", name, k), bus_if.out_data, vals[k*8 +: 8]);
            chk($sformatf("%s_last%0d", name, k), bus_if.out_last, (k == n - 1) ? 1 : 0);
            tick();
        end
        chk({name, "_flush_clear"}, sorter_clear, 1);
        chk({name, "_flush_done"}, done, 1);
        chk({name, "_flush_valid"}, bus_if.out_valid, 0);
        chk({name, "_flush_data"}, bus_if.out_data, 0);
        chk({name, "_flush_busy"}, busy, 1);
        tick();
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_clear"}, sorter_clear, 0);
        chk({name, "_idle_count"}, out_count, n);
    endtask

    initial begin
        int idx;
        int xfers;
        int cyc;
        bit fin;

        reset            = 1'b0;
        start            = 1'b0;
        cell_data_bus    = '0;
        cell_empty       = 8'hFF;
        bus_if.out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", bus_if.out_valid, 0);
        chk("rst_data", bus_if.out_data, 0);
        chk("rst_last", bus_if.out_last, 0);
        chk("rst_count", out_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear", sorter_clear, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Four leading entries, unoccupied cells hold junk
        cell_data_bus = {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'd20, 8'd9, 8'd7, 8'd3};
        cell_empty    = 8'hF0;
        do_start();
        chk("t1_busy", busy, 1);
        chk("t1_count", out_count, 4);
        run_stream("t1", 4, {32'h0, 8'd20, 8'd9, 8'd7, 8'd3});

        // All cells empty
        cell_empty = 8'hFF;
        do_start();
        chk("t2_valid", bus_if.out_valid, 0);
        chk("t2_count", out_count, 0);
        chk("t2_clear", sorter_clear, 1);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_idle_busy", busy, 0);
        chk("t2_idle_clear", sorter_clear, 0);
        chk("t2_idle_valid", bus_if.out_valid, 0);

        // Full snapshot 1..8, live bus overwritten after capture, ready 1,0,0,...
        cell_data_bus = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        cell_empty    = 8'h00;
        do_start();
        cell_data_bus = {8{8'hFF}};
        cell_empty    = 8'hFF;
        chk("t3_count", out_count, 8);
        idx   = 0;
        xfers = 0;
        cyc   = 0;
        fin   = 1'b0;
        while (!fin && cyc < 60) begin
            bus_if.out_ready = (cyc % 3 == 0);
            chk($sformatf("t3_valid_c%0d", cyc), bus_if.out_valid, 1);
            chk($sformatf("t3_data_c%0d", cyc), bus_if.out_data, idx + 1);
            chk($sformatf("t3_last_c%0d", cyc), bus_if.out_last, (idx == 7) ? 1 : 0);
            tick();
            if (bus_if.out_ready) begin
                xfers++;
                if (idx == 7) fin = 1'b1;
                else idx++;
            end
            cyc++;
        end
        chk("t3_xfers", xfers, 8);
        chk("t3_flush_clear", sorter_clear, 1);
        chk("t3_flush_done", done, 1);
        chk("t3_flush_valid", bus_if.out_valid, 0);
        tick();
        chk("t3_idle_busy", busy, 0);

        // Gap at cell 2: only cells 0 and 1 drained
        cell_data_bus = {8'h0, 8'h0, 8'h0, 8'h0, 8'd13, 8'd12, 8'd11, 8'd10};
        cell_empty    = 8'b1111_0100;
        do_start();
        chk("t5_count", out_count, 2);
        run_stream("t5", 2, {48'h0, 8'd11, 8'd10});

        // Reset mid-stream after two transfers
        cell_data_bus = {8'h0, 8'h0, 8'h0, 8'h0, 8'd8, 8'd7, 8'd6, 8'd5};
        cell_empty    = 8'hF0;
        do_start();
        bus_if.out_ready = 1'b1;
        chk("t6_data0", bus_if.out_data, 5);
        tick();
        chk("t6_data1", bus_if.out_data, 6);
        tick();
        chk("t6_data2", bus_if.out_data, 7);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", bus_if.out_valid, 0);
        chk("t6_rst_data", bus_if.out_data, 0);
        chk("t6_rst_last", bus_if.out_last, 0);
        chk("t6_rst_count", out_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_clear", sorter_clear, 0);
        chk("t6_rst_done", done, 0);
        tick();
        chk("t6_rst_clear2", sorter_clear, 0);
        chk("t6_rst_busy2", busy, 0);
        reset = 1'b1;
        tick();
        cell_data_bus = {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd42, 8'd41, 8'd40};
        cell_empty    = 8'hF8;
        do_start();
        chk("t6b_count", out_count, 3);
        run_stream("t6b", 3, {40'h0, 8'd42, 8'd41, 8'd40});

        // Start ignored while streaming: a second pulse must not queue a drain
        cell_data_bus = {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd99, 8'd50};
        cell_empty    = 8'hFC;
        bus_if.out_ready = 1'b0;
        do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_stream("t7", 2, {48'h0, 8'd99, 8'd50});
        tick();
        chk("t7_noqueue_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
